// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// fetch_sequencer_pkg
// Shared constants and types for the fetch/decode/execute sequencer.
// Revision: 1.0
// ============================================================================
package fetch_sequencer_pkg;

  localparam int ADDR_WIDTH_DEF  = 8;
  localparam int FETCH_TIMEOUT   = 15;
  localparam int INSTR_CNT_WIDTH = 16;
  localparam int STATE_WIDTH     = 3;

  localparam logic [2:0] STATE_IDLE   = 3'd0;
  localparam logic [2:0] STATE_FETCH  = 3'd1;
  localparam logic [2:0] STATE_DECODE = 3'd2;
  localparam logic [2:0] STATE_EXEC   = 3'd3;
  localparam logic [2:0] STATE_HALT   = 3'd4;
  localparam logic [2:0] STATE_FAULT  = 3'd5;

  typedef struct packed {
    logic clr;
    logic load;
    logic inc;
  } pc_ctl_t;

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_wait_timer.sv
`default_nettype none
// ============================================================================
// wait_timer
// 4-bit wait counter with clear/enable; flags the edge on which it hits TIMEOUT.
// Revision: 1.0
// ============================================================================
module wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 4'd1;
    end
  end

  // Flags the cycle whose closing edge makes the count equal TIMEOUT.
  assign expired_o = (count_d == 4'(TIMEOUT)) && !clr_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// fetch_sequencer
// Sequences the PC through fetch, decode and execute with memory handshake.
// Revision: 1.0
// ============================================================================
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int TIMEOUT    = FETCH_TIMEOUT
) (
  input  logic                       Clk,
  input  logic                       Rst_n,
  input  logic                       Run,
  input  logic                       Mem_Ready,
  input  logic                       Br_Req,
  input  logic [ADDR_WIDTH-1:0]      Br_Target,
  input  logic                       Halt_Req,
  output logic                       Mem_Req,
  output logic                       IR_Load,
  output logic                       Exec_En,
  output logic                       PC_Clr,
  output logic                       PC_Load,
  output logic                       PC_Inc,
  output logic [ADDR_WIDTH-1:0]      Dest_Reg,
  output logic                       Fault,
  output logic [INSTR_CNT_WIDTH-1:0] Instr_Count,
  output logic [STATE_WIDTH-1:0]     State
);

  logic [2:0]                 state_q, state_d;
  logic                       run_prev_q;
  logic                       mem_req_q, mem_req_d;
  logic                       ir_load_q, ir_load_d;
  logic                       exec_en_q, exec_en_d;
  pc_ctl_t                    ctl_q, ctl_d;
  logic [ADDR_WIDTH-1:0]      dest_q, dest_d;
  logic                       fault_q, fault_d;
  logic [INSTR_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                       expired;

  // Held clear outside FETCH so every fetch starts counting from zero.
  wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk_i     (Clk),
    .rst_ni    (Rst_n),
    .clr_i     (state_q != STATE_FETCH),
    .en_i      (!Mem_Ready),
    .expired_o (expired)
  );

  always_comb begin
    state_d   = state_q;
    ctl_d     = '0;
    ir_load_d = 1'b0;
    exec_en_d = 1'b0;
    dest_d    = dest_q;
    cnt_d     = cnt_q;
    fault_d   = fault_q;
    case (state_q)
      STATE_IDLE: begin
        if (Run) begin
          ctl_d.clr = 1'b1;
          state_d   = STATE_FETCH;
        end
      end
      STATE_FETCH: begin
        if (Mem_Ready) begin
          ir_load_d = 1'b1;
          state_d   = STATE_DECODE;
        end else if (expired) begin
          state_d = STATE_FAULT;
        end
      end
      STATE_DECODE: begin
        exec_en_d = 1'b1;
        state_d   = STATE_EXEC;
      end
      STATE_EXEC: begin
        cnt_d = cnt_q + 1'b1;
        if (Halt_Req || !Run) begin
          ctl_d.inc = 1'b1;
          state_d   = STATE_HALT;
        end else if (Br_Req) begin
          ctl_d.load = 1'b1;
          dest_d     = Br_Target;
          state_d    = STATE_FETCH;
        end else begin
          ctl_d.inc = 1'b1;
          state_d   = STATE_FETCH;
        end
      end
      STATE_HALT: begin
        // Resume only on a fresh 0->1 edge of Run.
        if (Run && !run_prev_q) begin
          state_d = STATE_FETCH;
        end
      end
      STATE_FAULT: begin
        state_d = STATE_FAULT;
      end
      default: begin
        state_d = STATE_FAULT;
      end
    endcase
    if (state_d == STATE_FAULT) begin
      fault_d = 1'b1;
    end
    mem_req_d = (state_d == STATE_FETCH);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= STATE_IDLE;
      run_prev_q <= 1'b0;
      mem_req_q  <= 1'b0;
      ir_load_q  <= 1'b0;
      exec_en_q  <= 1'b0;
      ctl_q      <= '0;
      dest_q     <= '0;
      fault_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      run_prev_q <= Run;
      mem_req_q  <= mem_req_d;
      ir_load_q  <= ir_load_d;
      exec_en_q  <= exec_en_d;
      ctl_q      <= ctl_d;
      dest_q     <= dest_d;
      fault_q    <= fault_d;
      cnt_q      <= cnt_d;
    end
  end

  assign Mem_Req     = mem_req_q;
  assign IR_Load     = ir_load_q;
  assign Exec_En     = exec_en_q;
  assign PC_Clr      = ctl_q.clr;
  assign PC_Load     = ctl_q.load;
  assign PC_Inc      = ctl_q.inc;
  assign Dest_Reg    = dest_q;
  assign Fault       = fault_q;
  assign Instr_Count = cnt_q;
  assign State       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// tb_fetch_sequencer
// Scoreboard bench: driver models memory/execute unit, monitor checks PC updates.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_fetch_sequencer;

  localparam int AW = 8;
  localparam int TO = 4;
  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3, S_HALT = 3'd4, S_FAULT = 3'd5;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic          Run = 1'b0;
  logic          Mem_Ready = 1'b0;
  logic          Br_Req = 1'b0;
  logic          Halt_Req = 1'b0;
  logic [AW-1:0] Br_Target = '0;
  logic          Mem_Req, IR_Load, Exec_En, PC_Clr, PC_Load, PC_Inc, Fault;
  logic [AW-1:0] Dest_Reg;
  logic [15:0]   Instr_Count;
  logic [2:0]    State;

  always #5 Clk = ~Clk;

  fetch_sequencer #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Run(Run), .Mem_Ready(Mem_Ready),
    .Br_Req(Br_Req), .Br_Target(Br_Target), .Halt_Req(Halt_Req),
    .Mem_Req(Mem_Req), .IR_Load(IR_Load), .Exec_En(Exec_En),
    .PC_Clr(PC_Clr), .PC_Load(PC_Load), .PC_Inc(PC_Inc),
    .Dest_Reg(Dest_Reg), .Fault(Fault), .Instr_Count(Instr_Count), .State(State)
  );

  typedef struct {
    logic [2:0]    ctl;   // {clr, load, inc}
    logic [AW-1:0] dest;
    logic [15:0]   cnt;
    logic [2:0]    st;
  } exp_t;

  exp_t          sb[$];
  int            n_checks = 0;
  int            n_pass = 0;
  bit            zw = 1'b0;
  logic [AW-1:0] pc_act;
  logic [AW-1:0] m_pc, m_dest;
  logic [15:0]   m_cnt;

  task automatic chk(input bit ok, input string nm, input string got, input string want);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %s, expected %s", nm, got, want);
  endtask

  // The PC register the sequencer steers, as it sits outside the block.
  always @(posedge Clk) begin
    if (PC_Clr) pc_act <= '0;
    else if (PC_Load) pc_act <= Dest_Reg;
    else if (PC_Inc) pc_act <= pc_act + 1'b1;
  end

  int       cyc = 0;
  int       last_pulse = -1;
  logic [2:0] m_ctl;
  exp_t     m_e;

  always @(negedge Clk) begin
    cyc++;
    if (!Rst_n) begin
      last_pulse = -1;
    end else if (PC_Clr || PC_Load || PC_Inc) begin
      m_ctl = {PC_Clr, PC_Load, PC_Inc};
      if (sb.size() == 0) begin
        chk(1'b0, "unexpected_pc_pulse", $sformatf("ctl=%b st=%0d", m_ctl, State), "no pulse");
      end else begin
        m_e = sb.pop_front();
        chk({m_ctl, Dest_Reg, Instr_Count, State} == {m_e.ctl, m_e.dest, m_e.cnt, m_e.st},
            "pc_update",
            $sformatf("ctl=%b dest=%h cnt=%0d st=%0d", m_ctl, Dest_Reg, Instr_Count, State),
            $sformatf("ctl=%b dest=%h cnt=%0d st=%0d", m_e.ctl, m_e.dest, m_e.cnt, m_e.st));
      end
      if (zw && last_pulse >= 0)
        chk((cyc - last_pulse) == 3, "zero_wait_period",
            $sformatf("%0d cycles", cyc - last_pulse), "3 cycles");
      last_pulse = cyc;
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input logic [2:0] ctl, input logic [2:0] st);
    exp_t e;
    e.ctl = ctl; e.dest = m_dest; e.cnt = m_cnt; e.st = st;
    sb.push_back(e);
  endtask

  task automatic model_reset();
    sb.delete();
    m_pc = '0; m_dest = '0; m_cnt = '0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({Mem_Req, IR_Load, Exec_En, PC_Clr, PC_Load, PC_Inc, Fault} == 7'b0 &&
        Dest_Reg == '0 && Instr_Count == 16'd0 && State == S_IDLE, nm,
        $sformatf("ctl=%b%b%b%b%b%b%b dest=%h cnt=%0d st=%0d", Mem_Req, IR_Load, Exec_En,
                  PC_Clr, PC_Load, PC_Inc, Fault, Dest_Reg, Instr_Count, State),
        "all zero, st=0");
  endtask

  task automatic start_run();
    Run = 1'b1;
    push(3'b100, S_FETCH);
    tick();
  endtask

  // op: 0 plain, 1 branch, 2 halt, 3 stop (Run=0), 4 halt+branch
  task automatic instr(input int lat, input int op, input logic [AW-1:0] tgt);
    int  n;
    bit  halted;
    n = 0;
    while (!Mem_Req && n < 20) begin tick(); n++; end
    if (!Mem_Req) begin
      chk(1'b0, "fetch_wait", "no Mem_Req in 20 cycles", "Mem_Req");
      return;
    end
    Mem_Ready = 1'b0;
    repeat (lat) tick();
    Mem_Ready = 1'b1;
    tick();
    Mem_Ready = 1'b0;
    chk(IR_Load && State == S_DECODE && pc_act == m_pc, "decode_pc",
        $sformatf("ir=%b st=%0d pc=%h", IR_Load, State, pc_act),
        $sformatf("ir=1 st=2 pc=%h", m_pc));
    tick();
    chk(Exec_En && State == S_EXEC, "exec_cycle",
        $sformatf("en=%b st=%0d", Exec_En, State), "en=1 st=3");
    Br_Req    = (op == 1 || op == 4);
    Halt_Req  = (op == 2 || op == 4);
    Br_Target = tgt;
    Run       = (op != 3);
    m_cnt++;
    halted = (op == 2 || op == 3 || op == 4);
    if (halted) begin
      m_pc++;
      push(3'b001, S_HALT);
    end else if (op == 1) begin
      m_pc = tgt; m_dest = tgt;
      push(3'b010, S_FETCH);
    end else begin
      m_pc++;
      push(3'b001, S_FETCH);
    end
    tick();
    Br_Req = 1'b0; Halt_Req = 1'b0; Br_Target = AW'($urandom);
    if (halted) begin
      if (op != 3) begin
        repeat (3) begin
          chk(State == S_HALT && !Mem_Req, "halt_hold",
              $sformatf("st=%0d req=%b", State, Mem_Req), "st=4 req=0");
          tick();
        end
        Run = 1'b0;
      end
      tick();
      Run = 1'b1;
      tick();
      chk(State == S_FETCH && Mem_Req, "resume",
          $sformatf("st=%0d req=%b", State, Mem_Req), "st=1 req=1");
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int n, op, r;
    repeat (2) tick();
    chk_all_zero("reset_outputs");
    model_reset();
    Rst_n = 1'b1;

    // Directed run: zero-wait, halt at PC=5, halt+branch, branch to 0x2A.
    zw = 1'b1;
    start_run();
    for (int i = 0; i < 12; i++) begin
      if (i == 6) zw = 1'b0;
      op = (i == 5) ? 2 : (i == 10) ? 4 : (i == 11) ? 1 : 0;
      instr(0, op, (i == 10) ? 8'h77 : 8'h2A);
      if (i == 9)
        chk(Instr_Count == 16'd10, "count_after_10",
            $sformatf("%0d", Instr_Count), "10");
    end

    for (int i = 0; i < 60; i++) begin
      r  = $urandom_range(0, 9);
      op = (r < 5) ? 0 : (r < 7) ? 1 : (r == 7) ? 2 : (r == 8) ? 3 : 4;
      instr($urandom_range(0, TO - 1), op, AW'($urandom));
    end
    tick();
    tick();
    chk(sb.size() == 0, "scoreboard_drained", $sformatf("%0d left", sb.size()), "0 left");

    // Asynchronous reset in the middle of a fetch.
    chk(State == S_FETCH && Mem_Req, "pre_reset_fetch",
        $sformatf("st=%0d req=%b", State, Mem_Req), "st=1 req=1");
    #2;
    Rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset_mid_fetch");
    model_reset();
    tick();
    Rst_n = 1'b1;

    // Memory never answers: fault after TO fetch cycles, then absorbing.
    Mem_Ready = 1'b0;
    start_run();
    n = 0;
    while (Mem_Req && n < 20) begin n++; tick(); end
    chk(n == TO, "fetch_cycles_before_fault", $sformatf("%0d", n), $sformatf("%0d", TO));
    chk(Fault && !Mem_Req && State == S_FAULT, "fault_entry",
        $sformatf("fault=%b req=%b st=%0d", Fault, Mem_Req, State), "fault=1 req=0 st=5");
    for (int i = 0; i < 8; i++) begin
      Run = 1'(i % 2); Br_Req = 1'($urandom); Halt_Req = 1'($urandom);
      Mem_Ready = 1'($urandom);
      tick();
      chk(Fault && !Mem_Req && State == S_FAULT, "fault_absorbing",
          $sformatf("fault=%b req=%b st=%0d", Fault, Mem_Req, State), "fault=1 req=0 st=5");
    end
    Br_Req = 1'b0; Halt_Req = 1'b0; Mem_Ready = 1'b0; Run = 1'b0;
    Rst_n = 1'b0;
    #1;
    chk_all_zero("fault_cleared_by_reset");
    model_reset();
    tick();
    Rst_n = 1'b1;
    tick();
    chk(sb.size() == 0, "final_drain", $sformatf("%0d left", sb.size()), "0 left");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
